// File: rtl/swd_host.sv
// Serial Wire Debug initiator: runs one DP/AP transaction or a line-reset sequence,
// generating SWCLK and driving/sampling SWDIO through a split o/oe/i pad interface.
module swd_host #(
   parameter int CLK_DIV     = 2,
   parameter int IDLE_CYCLES = 8,
   parameter int LRST_ONES   = 56
) (
   input  logic        sys_clock,
   input  logic        reset,
   input  logic        start,
   input  logic        line_reset,
   input  logic        apndp,
   input  logic        rnw,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [2:0]  ack,
   output logic [31:0] rdata,
   output logic        parity_err,
   output logic        swclk,
   output logic        swdio_o,
   output logic        swdio_oe,
   input  logic        swdio_i
);

   localparam int XFER_BITS = 46 + IDLE_CYCLES;
   localparam int LRST_BITS = LRST_ONES + 2;
   localparam int MAX_BITS  = (XFER_BITS > LRST_BITS) ? XFER_BITS : LRST_BITS;
   localparam int BW        = $clog2(MAX_BITS + 1);
   localparam int PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_REQ   = 4'd1;
   localparam logic [3:0] S_TRN1  = 4'd2;
   localparam logic [3:0] S_ACK   = 4'd3;
   localparam logic [3:0] S_WTRN  = 4'd4;
   localparam logic [3:0] S_WDATA = 4'd5;
   localparam logic [3:0] S_RDATA = 4'd6;
   localparam logic [3:0] S_RTRN  = 4'd7;
   localparam logic [3:0] S_TAIL  = 4'd8;
   localparam logic [3:0] S_LRST  = 4'd9;

   // With no idle bits configured the data phase finishes straight into IDLE.
   localparam logic [3:0] S_POST = (IDLE_CYCLES > 0) ? S_TAIL : S_IDLE;

   logic [3:0]    r_state;
   logic [BW-1:0] r_bit;
   logic [PW-1:0] r_phase;
   logic          r_half;
   logic          r_swclk;
   logic          r_o;
   logic          r_oe;
   logic          r_done;
   logic [2:0]    r_ack;
   logic [31:0]   r_rdata;
   logic          r_perr;

   logic [7:0]    r_req;
   logic [31:0]   r_wdata;
   logic          r_rnw;
   logic [31:0]   r_rsh;

   logic [3:0]    w_nstate;
   logic [BW-1:0] w_nbit;
   logic          w_last;
   logic          w_acc_start;
   logic          w_rise;

   function automatic logic [BW-1:0] last_bit(input logic [3:0] st);
      case (st)
         S_REQ:            last_bit = BW'(7);
         S_ACK:            last_bit = BW'(2);
         S_WDATA, S_RDATA: last_bit = BW'(32);
         S_TAIL:           last_bit = BW'(IDLE_CYCLES - 1);
         S_LRST:           last_bit = BW'(LRST_ONES + 1);
         default:          last_bit = '0;
      endcase
   endfunction

   // Returns {oe, o} for the bit about to start; released bits park o high.
   function automatic logic [1:0] bit_out(input logic [3:0] st, input logic [BW-1:0] idx);
      bit_out = 2'b01;
      case (st)
         S_REQ:   bit_out = {1'b1, r_req[idx[2:0]]};
         S_WDATA: bit_out = {1'b1, idx[5] ? (^r_wdata) : r_wdata[idx[4:0]]};
         S_TAIL:  bit_out = 2'b10;
         S_LRST:  bit_out = {1'b1, (idx < BW'(LRST_ONES))};
         default: bit_out = 2'b01;
      endcase
   endfunction

   assign w_acc_start = (r_state == S_IDLE) && start && !line_reset;
   assign w_rise      = (r_state != S_IDLE) && (r_phase == PH_LAST) && !r_half;

   always_comb begin
      w_last   = (r_bit == last_bit(r_state));
      w_nstate = r_state;
      w_nbit   = r_bit + 1'b1;
      if (w_last) begin
         w_nbit = '0;
         case (r_state)
            S_REQ:   w_nstate = S_TRN1;
            S_TRN1:  w_nstate = S_ACK;
            S_ACK:   w_nstate = (r_ack == 3'b001) ? (r_rnw ? S_RDATA : S_WTRN) : S_RTRN;
            S_WTRN:  w_nstate = S_WDATA;
            S_WDATA: w_nstate = S_POST;
            S_RDATA: w_nstate = S_RTRN;
            S_RTRN:  w_nstate = S_POST;
            default: w_nstate = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clock) begin
      if (w_acc_start) begin
         r_req   <= {1'b1, 1'b0, ^{apndp, rnw, addr}, addr[1], addr[0], rnw, apndp, 1'b1};
         r_wdata <= wdata;
         r_rnw   <= rnw;
      end
      if (w_rise && (r_state == S_RDATA) && !r_bit[5]) begin
         r_rsh <= {swdio_i, r_rsh[31:1]};
      end
   end

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_bit   <= '0;
         r_phase <= '0;
         r_half  <= 1'b0;
         r_swclk <= 1'b0;
         r_o     <= 1'b1;
         r_oe    <= 1'b0;
         r_done  <= 1'b0;
         r_ack   <= '0;
         r_rdata <= '0;
         r_perr  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            r_phase <= '0;
            r_half  <= 1'b0;
            r_swclk <= 1'b0;
            r_bit   <= '0;
            if (line_reset) begin
               r_state <= S_LRST;
               r_oe    <= 1'b1;
               r_o     <= 1'b1;
            end else if (start) begin
               r_state <= S_REQ;
               r_oe    <= 1'b1;
               r_o     <= 1'b1;
               r_ack   <= '0;
               r_perr  <= 1'b0;
            end
         end else if (r_phase != PH_LAST) begin
            r_phase <= r_phase + 1'b1;
         end else begin
            r_phase <= '0;
            if (!r_half) begin
               // Low phase over: raise SWCLK and sample the target.
               r_half  <= 1'b1;
               r_swclk <= 1'b1;
               if (r_state == S_ACK) begin
                  r_ack <= {swdio_i, r_ack[2:1]};
               end
               if ((r_state == S_RDATA) && r_bit[5]) begin
                  r_rdata <= r_rsh;
                  r_perr  <= (^r_rsh) != swdio_i;
               end
            end else begin
               r_half  <= 1'b0;
               r_swclk <= 1'b0;
               r_state <= w_nstate;
               r_bit   <= w_nbit;
               if (w_nstate == S_IDLE) begin
                  r_done <= 1'b1;
                  r_oe   <= 1'b0;
                  r_o    <= 1'b1;
               end else begin
                  {r_oe, r_o} <= bit_out(w_nstate, w_nbit);
               end
            end
         end
      end
   end

   assign busy       = (r_state != S_IDLE);
   assign done       = r_done;
   assign ack        = r_ack;
   assign rdata      = r_rdata;
   assign parity_err = r_perr;
   assign swclk      = r_swclk;
   assign swdio_o    = r_o;
   assign swdio_oe   = r_oe;

endmodule

// File: tb/tb_swd_host.sv
// Directed bench for swd_host: a small SWD target model answers each transaction
// and the wire activity is logged per SWCLK rise for comparison with hand-computed bits.
module tb_swd_host;

   localparam int CLK_DIV     = 2;
   localparam int IDLE_CYCLES = 8;
   localparam int LRST_ONES   = 56;

   logic        sys_clock  = 1'b0;
   logic        reset      = 1'b1;
   logic        start      = 1'b0;
   logic        line_reset = 1'b0;
   logic        apndp      = 1'b0;
   logic        rnw        = 1'b0;
   logic [1:0]  addr       = 2'b00;
   logic [31:0] wdata      = '0;
   logic        swdio_i    = 1'b1;
   logic        busy, done, parity_err, swclk, swdio_o, swdio_oe;
   logic [2:0]  ack;
   logic [31:0] rdata;

   swd_host #(.CLK_DIV(CLK_DIV), .IDLE_CYCLES(IDLE_CYCLES), .LRST_ONES(LRST_ONES)) dut (
      .sys_clock(sys_clock), .reset(reset), .start(start), .line_reset(line_reset),
      .apndp(apndp), .rnw(rnw), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .ack(ack), .rdata(rdata), .parity_err(parity_err),
      .swclk(swclk), .swdio_o(swdio_o), .swdio_oe(swdio_oe), .swdio_i(swdio_i)
   );

   always #5 sys_clock = ~sys_clock;

   int   vec_cnt = 0;
   int   err_cnt = 0;
   int   rise_tot = 0;
   int   base = 0;
   logic resp   [0:63];
   logic o_log  [0:4095];
   logic oe_log [0:4095];

   // Target model: logs host bits at each SWCLK rise, then presents the next response bit.
   initial begin : target
      int k;
      for (int i = 0; i < 64; i++) resp[i] = 1'b1;
      forever begin
         @(posedge swclk);
         o_log[rise_tot]  = swdio_o;
         oe_log[rise_tot] = swdio_oe;
         k = rise_tot - base + 1;
         rise_tot++;
         #1;
         swdio_i = (k < 64) ? resp[k] : 1'b1;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] wire_bits(input bit sel_oe, input int first, input int n);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[i] = sel_oe ? oe_log[base + first + i] : o_log[base + first + i];
      return v;
   endfunction

   task automatic set_resp(input logic [2:0] a, input logic [31:0] d, input logic par);
      for (int i = 0; i < 64; i++) resp[i] = 1'b1;
      resp[9]  = a[0];
      resp[10] = a[1];
      resp[11] = a[2];
      for (int i = 0; i < 32; i++) resp[12 + i] = d[i];
      resp[44] = par;
   endtask

   task automatic run_xact(input logic ap, input logic rd, input logic [1:0] a,
                           input logic [31:0] wd, output int lat);
      @(negedge sys_clock);
      apndp = ap; rnw = rd; addr = a; wdata = wd; start = 1'b1;
      base = rise_tot;
      @(negedge sys_clock);
      start = 1'b0; apndp = ~ap; rnw = ~rd; addr = ~a; wdata = ~wd;
      check_eq("busy_rise", busy, 1);
      lat = 1;
      while (!done && lat < 2000) begin
         @(negedge sys_clock);
         lat++;
      end
      if (!done) lat = -1;
   endtask

   initial begin : main
      int lat;
      int cnt;

      repeat (3) @(negedge sys_clock);
      check_eq("rst_swclk", swclk, 0);
      check_eq("rst_swdio_o", swdio_o, 1);
      check_eq("rst_swdio_oe", swdio_oe, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_ack", ack, 0);
      check_eq("rst_rdata", rdata, 0);
      check_eq("rst_perr", parity_err, 0);
      reset = 1'b0;
      repeat (2) @(negedge sys_clock);

      // DP read IDCODE, good parity
      set_resp(3'b001, 32'h0BA01477, 1'b1);
      run_xact(1'b0, 1'b1, 2'd0, 32'h0, lat);
      check_eq("rd_latency", lat, 217);
      check_eq("rd_req", wire_bits(0, 0, 8), 64'hA5);
      check_eq("rd_req_oe", wire_bits(1, 0, 8), 64'hFF);
      check_eq("rd_trn_ack_oe", wire_bits(1, 8, 4), 64'h0);
      check_eq("rd_data_oe", wire_bits(1, 12, 34), 64'h0);
      check_eq("rd_tail_o", wire_bits(0, 46, 8), 64'h0);
      check_eq("rd_tail_oe", wire_bits(1, 46, 8), 64'hFF);
      check_eq("rd_ack", ack, 3'b001);
      check_eq("rd_rdata", rdata, 32'h0BA01477);
      check_eq("rd_perr", parity_err, 0);
      check_eq("rd_busy_fall", busy, 0);
      @(negedge sys_clock);
      check_eq("rd_done_pulse", done, 0);

      // DP read addr 3 with different data
      set_resp(3'b001, 32'h12345678, 1'b1);
      run_xact(1'b0, 1'b1, 2'd3, 32'h0, lat);
      check_eq("rd2_req", wire_bits(0, 0, 8), 64'hBD);
      check_eq("rd2_rdata", rdata, 32'h12345678);
      check_eq("rd2_perr", parity_err, 0);

      // Same IDCODE read, wrong parity bit
      set_resp(3'b001, 32'h0BA01477, 1'b0);
      run_xact(1'b0, 1'b1, 2'd0, 32'h0, lat);
      check_eq("perr_rdata", rdata, 32'h0BA01477);
      check_eq("perr_flag", parity_err, 1);

      // DP write ABORT
      set_resp(3'b001, 32'h0, 1'b0);
      run_xact(1'b0, 1'b0, 2'd0, 32'h0000001E, lat);
      check_eq("wr_latency", lat, 217);
      check_eq("wr_req", wire_bits(0, 0, 8), 64'h81);
      check_eq("wr_trn_ack_wtrn_oe", wire_bits(1, 8, 5), 64'h0);
      check_eq("wr_data_oe", wire_bits(1, 13, 33), 64'h1_FFFF_FFFF);
      check_eq("wr_data", wire_bits(0, 13, 32), 64'h1E);
      check_eq("wr_parity", wire_bits(0, 45, 1), 64'h0);
      check_eq("wr_ack", ack, 3'b001);
      check_eq("wr_perr_clear", parity_err, 0);
      check_eq("wr_rdata_keep", rdata, 32'h0BA01477);

      // AP write with odd-parity data
      run_xact(1'b1, 1'b0, 2'd1, 32'h00000007, lat);
      check_eq("wr2_req", wire_bits(0, 0, 8), 64'h8B);
      check_eq("wr2_data", wire_bits(0, 13, 32), 64'h7);
      check_eq("wr2_parity", wire_bits(0, 45, 1), 64'h1);

      // AP read answered with WAIT
      set_resp(3'b010, 32'hDEADBEEF, 1'b0);
      run_xact(1'b1, 1'b1, 2'd1, 32'h0, lat);
      check_eq("wait_latency", lat, 85);
      check_eq("wait_bits", rise_tot - base, 21);
      check_eq("wait_req", wire_bits(0, 0, 8), 64'hAF);
      check_eq("wait_ack", ack, 3'b010);
      check_eq("wait_rdata_keep", rdata, 32'h0BA01477);
      check_eq("wait_perr", parity_err, 0);
      check_eq("wait_rtrn_oe", wire_bits(1, 12, 1), 64'h0);
      check_eq("wait_tail_o", wire_bits(0, 13, 8), 64'h0);
      check_eq("wait_tail_oe", wire_bits(1, 13, 8), 64'hFF);

      // line_reset together with start, plus a start while busy
      @(negedge sys_clock);
      line_reset = 1'b1; start = 1'b1; apndp = 1'b0; rnw = 1'b1; addr = 2'd0;
      base = rise_tot;
      @(negedge sys_clock);
      line_reset = 1'b0; start = 1'b0;
      cnt = 0;
      while (busy && cnt < 2000) begin
         cnt++;
         start = (cnt == 20);
         @(negedge sys_clock);
      end
      start = 1'b0;
      check_eq("lrst_busy_cycles", cnt, 232);
      check_eq("lrst_done", done, 1);
      check_eq("lrst_bits", rise_tot - base, 58);
      check_eq("lrst_ones", wire_bits(0, 0, 56), 64'h00FF_FFFF_FFFF_FFFF);
      check_eq("lrst_zeros", wire_bits(0, 56, 2), 64'h0);
      check_eq("lrst_oe", wire_bits(1, 0, 58), 64'h03FF_FFFF_FFFF_FFFF);
      check_eq("lrst_ack_keep", ack, 3'b010);
      repeat (5) @(negedge sys_clock);
      check_eq("lrst_no_late_start", busy, 0);

      // Reset in the middle of a read data phase
      set_resp(3'b001, 32'hCAFEF00D, 1'b0);
      @(negedge sys_clock);
      apndp = 1'b0; rnw = 1'b1; addr = 2'd0; start = 1'b1;
      base = rise_tot;
      @(negedge sys_clock);
      start = 1'b0;
      cnt = 0;
      while ((rise_tot - base) < 20 && cnt < 2000) begin
         @(negedge sys_clock);
         cnt++;
      end
      check_eq("mid_reached_rdata", (rise_tot - base) >= 20, 1);
      reset = 1'b1;
      #1;
      check_eq("mid_rst_swclk", swclk, 0);
      check_eq("mid_rst_oe", swdio_oe, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_rdata", rdata, 0);
      @(negedge sys_clock);
      reset = 1'b0;
      @(negedge sys_clock);
      set_resp(3'b001, 32'h0BA01477, 1'b1);
      run_xact(1'b0, 1'b1, 2'd0, 32'h0, lat);
      check_eq("post_rst_latency", lat, 217);
      check_eq("post_rst_req", wire_bits(0, 0, 8), 64'hA5);
      check_eq("post_rst_ack", ack, 3'b001);
      check_eq("post_rst_rdata", rdata, 32'h0BA01477);
      check_eq("post_rst_perr", parity_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
